// File: rtl/aer_decoder_layer2_slice10_if.sv
// Bundle of the AER decoder's frame-control, lane and publish signals.
// The master drives the lanes and frame control; the slave is the decoder.
interface aer_decoder_layer2_slice10_if;
  logic         start_i;
  logic [3:0]   error_class_i;
  logic [79:0]  aer_i;
  logic [9:0]   valid_i;
  logic         end_i;
  logic [199:0] hot_vector_o;
  logic [7:0]   spike_count_o;
  logic         frame_valid_o;
  logic         timeout_o;
  logic         addr_err_o;
  logic         dup_err_o;
  logic         busy_o;

  modport master (
    output start_i, error_class_i, aer_i, valid_i, end_i,
    input  hot_vector_o, spike_count_o, frame_valid_o, timeout_o,
           addr_err_o, dup_err_o, busy_o
  );

  modport slave (
    input  start_i, error_class_i, aer_i, valid_i, end_i,
    output hot_vector_o, spike_count_o, frame_valid_o, timeout_o,
           addr_err_o, dup_err_o, busy_o
  );
endinterface

// File: rtl/aer_decoder_layer2_slice10.sv
// Ten-lane AER frame decoder: undoes the encoder's lane rotation, builds a
// 200-bit spike vector per frame and publishes it on end_i or idle timeout.
module aer_decoder_layer2_slice10 #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  aer_decoder_layer2_slice10_if.slave   bus
);
  localparam logic [7:0] TIMEOUT_CMP = 8'(TIMEOUT_CYC);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t       r_state, w_state_next;
  logic [199:0] r_acc, r_hot;
  logic [7:0]   r_count, r_spike, r_idle;
  logic [3:0]   r_ec;
  logic         r_frame_valid, r_timeout, r_addr_err, r_dup_err;

  logic [255:0] w_acc_pad;
  logic [7:0]   w_lane_addr [10];
  logic [9:0]   w_legal, w_illegal, w_new, w_dup;
  logic [199:0] w_set, w_acc_upd;
  logic [3:0]   w_inc;
  logic [8:0]   w_cnt_sum;
  logic [7:0]   w_cnt_upd, w_idle_next;
  logic         w_timeout_hit, w_close;
  logic [3:0]   w_ec_norm;

  // Padding lets an illegal address >= 200 index the accumulator harmlessly.
  assign w_acc_pad = {56'd0, r_acc};

  for (genvar gi = 0; gi < 10; gi++) begin : g_lane
    logic [7:0] w_addr;
    logic [4:0] w_res_sum;
    logic [3:0] w_res_want, w_res_got;
    logic       w_seen;

    assign w_addr      = bus.aer_i[8*gi +: 8];
    assign w_res_sum   = 5'(gi + 10) - {1'b0, r_ec};
    assign w_res_want  = (w_res_sum >= 5'd10) ? 4'(w_res_sum - 5'd10) : w_res_sum[3:0];
    assign w_res_got   = 4'(w_addr % 8'd10);
    assign w_legal[gi] = bus.valid_i[gi] && (w_addr < 8'd200) && (w_res_got == w_res_want);
    assign w_illegal[gi] = bus.valid_i[gi] && !w_legal[gi];
    assign w_seen      = w_acc_pad[w_addr];
    assign w_new[gi]   = w_legal[gi] && !w_seen;
    assign w_dup[gi]   = w_legal[gi] && w_seen;
    assign w_lane_addr[gi] = w_addr;
  end

  // Legal lanes carry distinct residues, so the set bits never overlap.
  always_comb begin
    w_set = '0;
    w_inc = '0;
    for (int p = 0; p < 10; p++) begin
      if (w_new[p]) begin
        w_set[w_lane_addr[p]] = 1'b1;
        w_inc = w_inc + 4'd1;
      end
    end
  end

  assign w_acc_upd     = r_acc | w_set;
  assign w_cnt_sum     = {1'b0, r_count} + 9'(w_inc);
  assign w_cnt_upd     = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
  assign w_idle_next   = (|bus.valid_i) ? 8'd0 : r_idle + 8'd1;
  assign w_timeout_hit = (w_idle_next == TIMEOUT_CMP);
  assign w_close       = (r_state == S_COLLECT) && (bus.end_i || w_timeout_hit);
  assign w_ec_norm     = (bus.error_class_i > 4'd9) ? 4'd0 : bus.error_class_i;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start_i) w_state_next = S_COLLECT;
      S_COLLECT: begin
        if (bus.start_i)  w_state_next = S_COLLECT;
        else if (w_close) w_state_next = S_IDLE;
      end
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc         <= '0;
      r_hot         <= '0;
      r_count       <= '0;
      r_spike       <= '0;
      r_idle        <= '0;
      r_ec          <= '0;
      r_frame_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_addr_err    <= 1'b0;
      r_dup_err     <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_timeout     <= 1'b0;
      if (r_state == S_COLLECT) begin
        r_acc   <= w_acc_upd;
        r_count <= w_cnt_upd;
        r_idle  <= w_idle_next;
        if (|w_illegal) r_addr_err <= 1'b1;
        if (|w_dup)     r_dup_err  <= 1'b1;
        if (w_close) begin
          r_hot         <= w_acc_upd;
          r_spike       <= w_cnt_upd;
          r_frame_valid <= 1'b1;
          r_timeout     <= w_timeout_hit && !bus.end_i;
        end
      end
      // A start opens a fresh frame; it overrides this cycle's accumulation.
      if (bus.start_i) begin
        r_acc      <= '0;
        r_count    <= '0;
        r_idle     <= '0;
        r_addr_err <= 1'b0;
        r_dup_err  <= 1'b0;
        r_ec       <= w_ec_norm;
      end
    end
  end

  assign bus.hot_vector_o  = r_hot;
  assign bus.spike_count_o = r_spike;
  assign bus.frame_valid_o = r_frame_valid;
  assign bus.timeout_o     = r_timeout;
  assign bus.addr_err_o    = r_addr_err;
  assign bus.dup_err_o     = r_dup_err;
  assign bus.busy_o        = (r_state == S_COLLECT);
endmodule

// File: tb/tb_aer_decoder_layer2_slice10.sv
// Bench for the AER frame decoder: directed scenarios plus random traffic,
// every cycle compared against a frame-level reference model.
module tb_aer_decoder_layer2_slice10;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  aer_decoder_layer2_slice10_if bus ();

  aer_decoder_layer2_slice10 #(.TIMEOUT_CYC(T)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: one frame as a set of addresses.
  bit         m_collect;
  bit         m_seen [200];
  int         m_cnt, m_idle, m_ec, m_spike;
  bit         m_aerr, m_derr, m_fv, m_to;
  bit [199:0] m_hot;

  task automatic check_eq(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lane_res(input int p, input int ec);
    return (p - ec + 10) % 10;
  endfunction

  task automatic model_reset();
    m_collect = 0;
    foreach (m_seen[i]) m_seen[i] = 0;
    m_cnt = 0; m_idle = 0; m_ec = 0; m_spike = 0;
    m_aerr = 0; m_derr = 0; m_fv = 0; m_to = 0; m_hot = '0;
  endtask

  task automatic model_step();
    bit any, hit_to;
    int a;
    m_fv = 0;
    m_to = 0;
    if (m_collect) begin
      any = 0;
      for (int p = 0; p < 10; p++) begin
        if (bus.valid_i[p]) begin
          any = 1;
          a = int'(bus.aer_i[8*p +: 8]);
          if (a < 200 && (a % 10) == lane_res(p, m_ec)) begin
            if (m_seen[a]) m_derr = 1;
            else begin
              m_seen[a] = 1;
              if (m_cnt < 255) m_cnt++;
            end
          end else begin
            m_aerr = 1;
          end
        end
      end
      m_idle = any ? 0 : m_idle + 1;
      hit_to = (m_idle == T);
      if (bus.end_i || hit_to) begin
        for (int i = 0; i < 200; i++) m_hot[i] = m_seen[i];
        m_spike = m_cnt;
        m_fv = 1;
        m_to = hit_to && !bus.end_i;
        m_collect = 0;
      end
    end
    if (bus.start_i) begin
      m_collect = 1;
      foreach (m_seen[i]) m_seen[i] = 0;
      m_cnt = 0; m_idle = 0; m_aerr = 0; m_derr = 0;
      m_ec = (bus.error_class_i > 9) ? 0 : int'(bus.error_class_i);
    end
  endtask

  task automatic check_all();
    check_eq("hot_vector", bus.hot_vector_o, m_hot);
    check_eq("spike_count", 200'(bus.spike_count_o), 200'(m_spike));
    check_eq("frame_valid", 200'(bus.frame_valid_o), 200'(m_fv));
    check_eq("timeout", 200'(bus.timeout_o), 200'(m_to));
    check_eq("addr_err", 200'(bus.addr_err_o), 200'(m_aerr));
    check_eq("dup_err", 200'(bus.dup_err_o), 200'(m_derr));
    check_eq("busy", 200'(bus.busy_o), 200'(m_collect));
  endtask

  task automatic drive(input bit s, input logic [3:0] c, input bit e,
                       input logic [9:0] v, input logic [79:0] a);
    bus.start_i = s;
    bus.error_class_i = c;
    bus.end_i = e;
    bus.valid_i = v;
    bus.aer_i = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  function automatic logic [79:0] lanes2(input int p0, input int a0, input int p1, input int a1);
    logic [79:0] r;
    r = '0;
    r[8*p0 +: 8] = 8'(a0);
    r[8*p1 +: 8] = 8'(a1);
    return r;
  endfunction

  initial begin
    logic [9:0]  v;
    logic [79:0] a;
    int          sel;
    bit          s, e;

    drive(0, 0, 0, '0, '0);
    model_reset();
    #2;
    check_all();
    #10 reset_n = 1'b1;

    // Two legal events, closed by end_i.
    drive(1, 4'd0, 0, '0, '0); tick();
    drive(0, 4'd0, 0, 10'b0000001001, lanes2(0, 20, 3, 13)); tick();
    drive(0, 4'd0, 1, '0, '0); tick();
    check_eq("basic_count", 200'(bus.spike_count_o), 200'(2));
    check_eq("basic_bits", 200'({bus.hot_vector_o[20], bus.hot_vector_o[13]}), 200'(2'b11));

    // Rotation 1: lane0/9 and lane1/0 legal, then lane0/0 illegal.
    drive(1, 4'd1, 0, '0, '0); tick();
    drive(0, 4'd0, 0, 10'b0000000011, lanes2(0, 9, 1, 0)); tick();
    drive(0, 4'd0, 0, 10'b0000000001, lanes2(0, 0, 1, 0)); tick();
    drive(0, 4'd0, 1, '0, '0); tick();
    check_eq("rot_count", 200'(bus.spike_count_o), 200'(2));
    check_eq("rot_addr_err", 200'(bus.addr_err_o), 200'(1));

    // Out-of-range address and a duplicate.
    drive(1, 4'd12, 0, '0, '0); tick();
    drive(0, 4'd0, 0, 10'b0000100000, lanes2(5, 205, 0, 0)); tick();
    drive(0, 4'd0, 0, 10'b0000100000, lanes2(5, 15, 0, 0)); tick();
    drive(0, 4'd0, 0, 10'b0000100000, lanes2(5, 15, 0, 0)); tick();
    drive(0, 4'd0, 1, '0, '0); tick();
    check_eq("dup_count", 200'(bus.spike_count_o), 200'(1));
    check_eq("dup_flag", 200'({bus.dup_err_o, bus.addr_err_o}), 200'(2'b11));

    // Idle timeout after one event.
    drive(1, 4'd0, 0, '0, '0); tick();
    drive(0, 4'd0, 0, 10'b0000000001, lanes2(0, 30, 1, 0)); tick();
    drive(0, 4'd0, 0, '0, '0);
    for (int i = 0; i < T; i++) tick();
    check_eq("to_pulse", 200'({bus.frame_valid_o, bus.timeout_o, bus.busy_o}), 200'(3'b110));

    // start_i and end_i together with event 42 on lane 2.
    drive(1, 4'd0, 0, '0, '0); tick();
    drive(1, 4'd0, 1, 10'b0000000100, lanes2(2, 42, 0, 0)); tick();
    check_eq("restart_pub", 200'({bus.hot_vector_o[42], bus.frame_valid_o, bus.busy_o}), 200'(3'b111));
    drive(0, 4'd0, 1, '0, '0); tick();
    check_eq("restart_empty", 200'(bus.spike_count_o), 200'(0));

    // Reset in mid-frame, then lanes without start.
    drive(1, 4'd3, 0, '0, '0); tick();
    drive(0, 4'd0, 0, 10'b0000001000, lanes2(3, 0, 0, 0)); tick();
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk) reset_n = 1'b1;
    drive(0, 4'd0, 0, 10'b0000000001, lanes2(0, 10, 0, 0)); tick();
    drive(0, 4'd0, 1, 10'b0000000001, lanes2(0, 20, 0, 0)); tick();

    // Random traffic.
    for (int cyc = 0; cyc < 600; cyc++) begin
      v = '0;
      a = '0;
      if ($urandom_range(0, 99) >= 35) begin
        for (int p = 0; p < 10; p++) begin
          if ($urandom_range(0, 99) < 30) begin
            v[p] = 1'b1;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      a[8*p +: 8] = 8'(lane_res(p, m_ec) + 10 * int'($urandom_range(0, 19)));
            else if (sel < 8) a[8*p +: 8] = 8'(lane_res(p, m_ec) + 10 * int'($urandom_range(0, 2)));
            else              a[8*p +: 8] = 8'($urandom_range(0, 255));
          end
        end
      end
      s = m_collect ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 30);
      e = ($urandom_range(0, 99) < 8);
      drive(s, 4'($urandom_range(0, 15)), e, v, a);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/aer_decoder_layer2_slice10.md
AER_DECODER_LAYER2_SLICE10 -- requirements
Module: aer_decoder_layer2_slice10

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, number of consecutive idle COLLECT cycles (valid_i==0) that closes a frame; legal range 1..255.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  frame start; clears accumulator and latches error_class_i.
REQ-005 error_class_i  in  4  lane rotation applied by the encoder; values 10..15 treated as 0.
REQ-006 aer_i  in  80  lane p address = aer_i[8p+7:8p], p=0..9.
REQ-007 valid_i  in  10  lane p address valid.
REQ-008 end_i  in  1  frame end.
REQ-009 hot_vector_o  out  200  published spike vector; bit a set if address a was received.
REQ-010 spike_count_o  out  8  published count of distinct legal addresses, saturating at 255.
REQ-011 frame_valid_o  out  1  one-cycle pulse; hot_vector_o/spike_count_o updated this cycle.
REQ-012 timeout_o  out  1  one-cycle pulse coincident with frame_valid_o when the frame closed by timeout.
REQ-013 addr_err_o  out  1  sticky; illegal address seen in current frame.
REQ-014 dup_err_o  out  1  sticky; repeated legal address seen in current frame.
REQ-015 busy_o  out  1  high while state is COLLECT.

Function
REQ-016 The block SHALL implement two states, IDLE and COLLECT, with a 200-bit accumulator, an 8-bit running count, and an 8-bit idle counter.
REQ-017 IDLE: start_i -> COLLECT; accumulator, running count, idle counter, addr_err_o and dup_err_o cleared; ec latched. valid_i and end_i are ignored.
REQ-018 COLLECT, per lane p with valid_i[p]=1: address a is legal iff a<200 and (a mod 10) == ((p - ec) mod 10).
REQ-019 Legal a with accumulator bit a clear -> set bit a, count +1. Legal a with bit a already set -> dup_err_o=1, no count change.
REQ-020 Illegal a -> addr_err_o=1; accumulator and count unchanged.
REQ-021 Up to 10 lanes per cycle SHALL be accepted in one cycle. Count increment is the number of newly set bits, saturating at 255.
REQ-022 Legal addresses on distinct lanes have distinct residues, so they never collide within one cycle.
REQ-023 Frame close: end_i=1 in COLLECT, or idle counter reaching TIMEOUT_CYC.
REQ-024 Idle counter: +1 per COLLECT cycle with valid_i==0; cleared on any valid lane.
REQ-025 On close at edge N, the accumulator including cycle-N events SHALL be published to hot_vector_o and spike_count_o. frame_valid_o=1 during cycle N+1, then state -> IDLE.
REQ-026 timeout_o=1 only when the close was by timeout and end_i=0.
REQ-027 start_i in COLLECT without close: the frame is discarded (no publish), accumulator is restarted, ec is re-latched, state stays COLLECT.
REQ-028 start_i and close in the same cycle: the old frame (with cycle-N events) is published, a new frame begins, state stays COLLECT.
REQ-029 Sticky error flags SHALL NOT be cleared at publish; they persist until the next start_i.
REQ-030 hot_vector_o and spike_count_o hold their values between publishes.

Reset
REQ-031 Asserting reset_n low SHALL immediately force:
- state IDLE;
- accumulator, counters and all outputs to 0, including hot_vector_o=0, spike_count_o=0, frame_valid_o=0, timeout_o=0, addr_err_o=0, dup_err_o=0, busy_o=0.
REQ-032 Reset mid-frame SHALL discard the frame with no publish. After release, only start_i resumes collection.

Verification
REQ-033 ec=0; start, then lanes 0,3 carry 20,13; end_i next cycle -> next cycle frame_valid_o=1, hot_vector_o bits 20,13 set, spike_count_o=2, errors 0.
REQ-034 ec=1; lane 0 carries 9, lane 1 carries 0 -> both legal. ec=1; lane 0 carries 0 -> addr_err_o=1, bit 0 not set.
REQ-035 ec=0; address 205 on lane 5 -> addr_err_o=1, no count. Address 15 twice in separate cycles -> dup_err_o=1, spike_count_o=1.
REQ-036 TIMEOUT_CYC=4; one event, then valid_i=0 for 4 cycles -> frame_valid_o and timeout_o pulse together, busy_o falls.
REQ-037 start_i and end_i in the same COLLECT cycle, with event 42 on lane 2 -> old frame published including bit 42. New frame accumulator empty, busy_o stays 1.
REQ-038 reset_n low mid-COLLECT -> all outputs 0 immediately, no frame_valid_o. valid_i after release and before start_i -> no effect.
